// File: rtl/wisc_pkg.sv
// Shared fetch/decode definitions: default NOP and HALT encodings,
// instruction-queue state enum and the queued entry format.
package wisc_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OPC  = 5'b00000;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL,
    HALTED
  } q_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        err;
  } if_entry_t;

endpackage

// File: rtl/if_id_storage.sv
// DEPTH-entry register array for the IF/ID queue: one synchronous write
// port and a combinational read port. Storage is deliberately not reset.
module if_id_storage
  import wisc_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  if_entry_t                wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output if_entry_t                rd_data
);

  if_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: buffers {instr, pc2, err}, supplies NOPs
// to decode when empty, drains on HALT and discards everything on flush.
module if_id_queue #(
  parameter int unsigned DEPTH     = 2,
  parameter logic [15:0] NOP_INSTR = wisc_pkg::NOP_INSTR,
  parameter logic [4:0]  HALT_OPC  = wisc_pkg::HALT_OPC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [15:0]            if_instr,
  input  logic [15:0]            if_pc2,
  input  logic                   if_err,
  output logic                   if_ready,
  input  logic                   id_ready,
  input  logic                   flush,
  output logic                   id_valid,
  output logic [15:0]            id_instr,
  output logic [15:0]            id_pc2,
  output logic                   id_err,
  output logic                   halted,
  output logic [$clog2(DEPTH):0] count
);

  import wisc_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  q_state_t        state, state_n;
  logic [PW-1:0]   rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
  logic [CW-1:0]   count_n;
  logic            push, pop, push_halt;
  if_entry_t       wr_data, head;

  assign if_ready  = (state != FULL) && (state != HALTED);
  assign id_valid  = (count != '0);
  assign push      = if_valid & if_ready;
  assign pop       = id_ready & id_valid;
  assign push_halt = push && (if_instr[15:11] == HALT_OPC);
  assign halted    = (state == HALTED);

  assign wr_data = '{instr: if_instr, pc2: if_pc2, err: if_err};

  if_id_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .wr_en   (push & ~flush),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr),
    .rd_data (head)
  );

  assign id_instr = id_valid ? head.instr : NOP_INSTR;
  assign id_pc2   = id_valid ? head.pc2   : 16'h0000;
  assign id_err   = id_valid ? head.err   : 1'b0;

  // State follows the updated occupancy unless HALT is (or becomes) sticky;
  // flush overrides everything, including a HALT pushed in the same cycle.
  always_comb begin
    state_n  = state;
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    if (flush) begin
      state_n  = EMPTY;
      rd_ptr_n = '0;
      wr_ptr_n = '0;
      count_n  = '0;
    end else begin
      if (push) wr_ptr_n = wr_ptr + PW'(1);
      if (pop)  rd_ptr_n = rd_ptr + PW'(1);
      count_n = count + CW'(push) - CW'(pop);
      if ((state == HALTED) || push_halt) state_n = HALTED;
      else if (count_n == '0)             state_n = EMPTY;
      else if (count_n == CW'(DEPTH))     state_n = FULL;
      else                                state_n = PARTIAL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_n;
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count  <= count_n;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, asynchronous reset check and
// a randomized run against a queue-based reference model.
module tb_if_id_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_err, id_ready, flush;
  logic [15:0] if_instr, if_pc2;
  logic        if_ready, id_valid, id_err, halted;
  logic [15:0] id_instr, id_pc2;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(16'h0800), .HALT_OPC(5'b00000)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_pc2   (if_pc2),
    .if_err   (if_err),
    .if_ready (if_ready),
    .id_ready (id_ready),
    .flush    (flush),
    .id_valid (id_valid),
    .id_instr (id_instr),
    .id_pc2   (id_pc2),
    .id_err   (id_err),
    .halted   (halted),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] ins;
    logic [15:0] pc;
    logic        er;
    logic        rdy;
    logic        fl;
    logic        ev;
    logic [15:0] ei;
    logic [15:0] ep;
    logic        ee;
    int          ec;
    logic        erdy;
    logic        eh;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        err;
  } ent_t;

  vec_t vecs[$];
  ent_t mq[$];
  logic m_halted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [15:0] ei,
                         input logic [15:0] ep, input logic ee, input int ec,
                         input logic erdy, input logic eh);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(ev));
    chk({tag, ".id_instr"}, 32'(id_instr), 32'(ei));
    chk({tag, ".id_pc2"},   32'(id_pc2),   32'(ep));
    chk({tag, ".id_err"},   32'(id_err),   32'(ee));
    chk({tag, ".count"},    32'(count),    32'(ec));
    chk({tag, ".if_ready"}, 32'(if_ready), 32'(erdy));
    chk({tag, ".halted"},   32'(halted),   32'(eh));
  endtask

  function automatic vec_t mk(logic iv, logic [15:0] ins, logic [15:0] pc, logic er,
                              logic rdy, logic fl, logic ev, logic [15:0] ei,
                              logic [15:0] ep, logic ee, int ec, logic erdy, logic eh);
    vec_t v;
    v.iv = iv; v.ins = ins; v.pc = pc; v.er = er; v.rdy = rdy; v.fl = fl;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ee = ee; v.ec = ec; v.erdy = erdy; v.eh = eh;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [15:0] ins, input logic [15:0] pc,
                       input logic er, input logic rdy, input logic fl);
    if_valid = iv; if_instr = ins; if_pc2 = pc; if_err = er; id_ready = rdy; flush = fl;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 16'h0800, 16'h0000, 1'b0, 0, 1'b1, 1'b0);
    rst = 1'b1;

    // Mid-stream asynchronous reset with two entries queued.
    drive(1'b1, 16'h4001, 16'h0002, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 16'h4102, 16'h0004, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("arst.pre_count", 32'(count), 32'd2);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_all("arst", 1'b0, 16'h0800, 16'h0000, 1'b0, 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;

    //         iv  ins       pc        er    rdy   fl  | ev  ei        ep        ee  ec rdy  h
    vecs.push_back(mk(1, 16'h4001, 16'h0002, 0, 1, 0, 1, 16'h4001, 16'h0002, 0, 1, 1, 0));
    vecs.push_back(mk(1, 16'h4102, 16'h0004, 0, 1, 0, 1, 16'h4102, 16'h0004, 0, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk(1, 16'h4203, 16'h0006, 1, 0, 0, 1, 16'h4203, 16'h0006, 1, 1, 1, 0));
    vecs.push_back(mk(1, 16'h4304, 16'h0008, 0, 0, 0, 1, 16'h4203, 16'h0006, 1, 2, 0, 0));
    vecs.push_back(mk(1, 16'h4405, 16'h000a, 1, 0, 0, 1, 16'h4203, 16'h0006, 1, 2, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, 1, 16'h4304, 16'h0008, 0, 1, 1, 0));
    vecs.push_back(mk(1, 16'h4506, 16'h000c, 1, 0, 0, 1, 16'h4304, 16'h0008, 0, 2, 0, 0));
    vecs.push_back(mk(1, 16'h4607, 16'h000e, 0, 0, 1, 0, 16'h0800, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0800, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk(1, 16'h4708, 16'h0010, 0, 0, 0, 1, 16'h4708, 16'h0010, 0, 1, 1, 0));
    vecs.push_back(mk(1, 16'h4809, 16'h0012, 1, 0, 1, 0, 16'h0800, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0800, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk(1, 16'h4001, 16'h0002, 0, 0, 0, 1, 16'h4001, 16'h0002, 0, 1, 1, 0));
    vecs.push_back(mk(1, 16'h0000, 16'h0004, 0, 0, 0, 1, 16'h4001, 16'h0002, 0, 2, 0, 1));
    vecs.push_back(mk(1, 16'h4202, 16'h0006, 0, 1, 0, 1, 16'h0000, 16'h0004, 0, 1, 0, 1));
    vecs.push_back(mk(1, 16'h4202, 16'h0006, 0, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 16'h4202, 16'h0006, 0, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0800, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk(1, 16'h0000, 16'h0008, 0, 0, 1, 0, 16'h0800, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0800, 16'h0000, 0, 0, 1, 0));
    vecs.push_back(mk(1, 16'h4a01, 16'h0020, 1, 1, 0, 1, 16'h4a01, 16'h0020, 1, 1, 1, 0));
    vecs.push_back(mk(1, 16'h4a02, 16'h0022, 0, 1, 0, 1, 16'h4a02, 16'h0022, 0, 1, 1, 0));
    vecs.push_back(mk(1, 16'h4a03, 16'h0024, 1, 1, 0, 1, 16'h4a03, 16'h0024, 1, 1, 1, 0));
    vecs.push_back(mk(1, 16'h4a04, 16'h0026, 0, 1, 0, 1, 16'h4a04, 16'h0026, 0, 1, 1, 0));
    vecs.push_back(mk(1, 16'h4a05, 16'h0028, 1, 1, 0, 1, 16'h4a05, 16'h0028, 1, 1, 1, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0800, 16'h0000, 0, 0, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ins, vecs[i].pc, vecs[i].er, vecs[i].rdy, vecs[i].fl);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].ee,
              vecs[i].ec, vecs[i].erdy, vecs[i].eh);
    end

    // Randomized run; DUT is empty and not halted after the table.
    mq.delete();
    m_halted = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic        iv, rdy, fl, m_ready, m_push, m_pop;
      logic [15:0] ins;
      ent_t        e;
      iv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      ins = 16'($urandom);
      if ($urandom_range(0, 11) == 0) ins[15:11] = 5'b00000;
      else if (ins[15:11] == 5'b00000) ins[15:11] = 5'b00001;
      e.instr = ins;
      e.pc2   = 16'($urandom);
      e.err   = 1'($urandom);
      drive(iv, ins, e.pc2, e.err, rdy, fl);

      m_ready = !m_halted && (mq.size() < DEPTH);
      if (fl) begin
        mq.delete();
        m_halted = 1'b0;
      end else begin
        m_pop  = rdy && (mq.size() > 0);
        m_push = iv && m_ready;
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back(e);
          if (ins[15:11] == 5'b00000) m_halted = 1'b1;
        end
      end

      @(posedge clk); #1;
      if (mq.size() > 0)
        chk_all($sformatf("rnd%0d", n), 1'b1, mq[0].instr, mq[0].pc2, mq[0].err,
                mq.size(), !m_halted && (mq.size() < DEPTH), m_halted);
      else
        chk_all($sformatf("rnd%0d", n), 1'b0, 16'h0800, 16'h0000, 1'b0, 0,
                !m_halted, m_halted);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between the fetch stage and decode; replaces a bare IF/ID latch.
- Captures {instr, PC_2, align_err} from fetch whenever fetch presents a valid word.
- Holds up to DEPTH entries so that instruction-cache stalls and decode hazards do not have to be resolved in the same cycle.
- Handles pipeline flush on taken branch/jump, NOP insertion toward decode, and halt draining.

Parameters:
- DEPTH, 2, number of entries; power of two, at least 2.
- NOP_INSTR, 16'h0800, instruction presented to decode when no valid entry exists.
- HALT_OPC, 5'b00000, opcode (instr[15:11]) identifying HALT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_valid  in  1  fetch presents a valid word this cycle (cache hit or mem_done, no fetch NOP).
- if_instr  in  16  fetched instruction.
- if_pc2  in  16  PC+2 of the fetched instruction.
- if_err  in  1  instruction memory alignment error.
- if_ready  out  1  queue accepts a push this cycle; fetch holds its PC when 0.
- id_ready  in  1  decode consumes the head this cycle (i.e. ~hazard).
- flush  in  1  taken branch/jump/exception resolved; discard all entries.
- id_valid  out  1  head entry valid.
- id_instr  out  16  head instruction, or NOP_INSTR when id_valid=0.
- id_pc2  out  16  head PC+2, 16'h0000 when id_valid=0.
- id_err  out  1  head alignment error, 0 when id_valid=0.
- halted  out  1  HALT has been accepted; no further pushes.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, asynchronous): rd/wr pointers=0, count=0, state=EMPTY. Outputs: id_valid=0, id_instr=NOP_INSTR, id_pc2=0, id_err=0, halted=0, if_ready=1. Entry storage is not reset.
- Push = if_valid & if_ready. Pop = id_ready & id_valid.
- Latency:
  - A pushed entry becomes visible at the head on the cycle after the push. There is no combinational bypass from if_* to id_*.
  - Head outputs are driven combinationally from storage at rd_ptr.
- if_ready = (state != FULL) & (state != HALTED). It depends on registered state only; there is no combinational path from id_ready.
- FSM states: EMPTY, PARTIAL (0 < count < DEPTH), FULL, HALTED.
  - EMPTY: push goes to PARTIAL (FULL if DEPTH=1, which is not allowed).
  - PARTIAL: push only raises count; pop only lowers count; push and pop together leave count unchanged. Reaching count 0 goes to EMPTY; reaching DEPTH goes to FULL.
  - FULL: pop goes to PARTIAL. A push cannot occur because if_ready=0.
  - Any state: a push of an instruction with instr[15:11]==HALT_OPC goes to HALTED after the entry is written. halted=1 from the following cycle.
  - HALTED: pops continue until count=0. After that, id_valid=0 and NOP_INSTR is presented. The block stays in HALTED until flush or reset.
- Flush (priority over push and pop in the same cycle):
  - Pointers and count clear and state goes to EMPTY on the next edge. Any concurrent push is dropped.
  - halted clears, because a HALT behind a mispredicted path is speculative.
  - If flush and a HALT push occur together, the block goes to EMPTY, not HALTED.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count never exceeds DEPTH and never underflows. Pop when empty is impossible because id_valid=0.
- An entry with if_err=1 is queued like any other. Decode/exception logic acts on id_err.
- id_ready is ignored while id_valid=0.

Decomposition:
- Shared package (wisc_pkg):
  - NOP_INSTR and HALT_OPC constants.
  - Queue-state enum {EMPTY, PARTIAL, FULL, HALTED}.
  - Packed struct if_entry_t {instr[15:0], pc2[15:0], err}.
- One natural sub-module, if_id_storage: DEPTH x 33-bit register array with write port (wr_en, wr_ptr, data) and combinational read at rd_ptr.
- Pointers, count and the FSM stay in if_id_queue.

Test Plan:
- Reset then idle: rst=0 mid-stream with count=2 -> immediately id_valid=0, id_instr=16'h0800, count=0, if_ready=1.
- Back-to-back flow: push 16'h4001/pc2 16'h0002, then 16'h4102/16'h0004, with id_ready=1 -> each appears at head one cycle after its push, in order. count peaks at 1.
- Fill and stall: id_ready=0, push three words -> count=2, if_ready=0 after the second push, third word not accepted. Then id_ready=1 for one cycle -> head advances, count=1, if_ready=1.
- Flush with concurrent push: count=2, flush=1 and if_valid=1 in the same cycle -> next cycle count=0, id_valid=0, id_instr=16'h0800. The pushed word never appears.
- Halt drain: push 16'h4001 then HALT 16'h0000, then offer 16'h4202 -> halted=1 and if_ready=0 after the HALT push. 16'h4202 is never queued. Both entries pop, then NOP_INSTR is held indefinitely. A later flush -> halted=0 and state EMPTY.
- Error propagation plus pointer wrap: push 5 entries with alternating if_err under steady pops -> id_err follows each entry exactly across pointer wrap-around.
